// File: rtl/sponge_pkg.sv
// Shared types and constants for the sponge (SHAKE) round/absorb/squeeze controller.
package sponge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_PERMUTE     = 2'd1,
      ST_ABSORB_WAIT = 2'd2,
      ST_OUTPUT      = 2'd3
   } sponge_state_t;

   typedef enum logic {
      MODE_SHAKE128 = 1'b0,
      MODE_SHAKE256 = 1'b1
   } sponge_mode_t;

   localparam int RATE_128           = 168;
   localparam int RATE_256           = 136;
   localparam int DEFAULT_NUM_ROUNDS = 24;

endpackage

// File: rtl/sponge_ctrl_round_counter.sv
// Permutation round counter: counts 0..NUM_ROUNDS-1 while enabled, wraps to 0 after the last round.
module round_counter
#(
   parameter int NUM_ROUNDS = 24,
   parameter int ROUND_W    = $clog2(NUM_ROUNDS)
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   output logic [ROUND_W-1:0] idx,
   output logic               last
);

   assign last = (idx == ROUND_W'(NUM_ROUNDS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (en) begin
         idx <= last ? '0 : idx + ROUND_W'(1);
      end
   end

endmodule

// File: rtl/sponge_ctrl.sv
// Sponge controller: sequences absorb, NUM_ROUNDS permutation rounds and multi-block squeeze output.
module sponge_ctrl
   import sponge_pkg::*;
#(
   parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS,
   parameter int OUT_CNT_W  = 16,
   parameter int ROUND_W    = $clog2(NUM_ROUNDS)
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 abort,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic                 in_mode,
   input  logic [OUT_CNT_W-1:0] in_out_blocks,
   input  logic                 out_ready,
   output logic                 in_ready,
   output logic                 absorb_en,
   output logic                 state_clr,
   output logic                 round_en,
   output logic [ROUND_W-1:0]   round_idx,
   output logic                 mode_q,
   output logic                 out_valid,
   output logic                 out_last,
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   localparam logic [1:0] IDLE        = ST_IDLE;
   localparam logic [1:0] PERMUTE     = ST_PERMUTE;
   localparam logic [1:0] ABSORB_WAIT = ST_ABSORB_WAIT;
   localparam logic [1:0] OUTPUT      = ST_OUTPUT;

   // Handshakes: a block moves on in_valid && in_ready, a squeeze block on out_valid && out_ready;
   // valid/ready are independent, and abort withdraws in_ready so no block is taken that cycle.
   logic [1:0]           state_q, state_d;
   logic [OUT_CNT_W-1:0] remaining_q;
   logic                 last_q;
   logic                 squeeze_q;
   logic                 rc_last;
   logic                 accept;
   logic                 out_hs;
   logic                 rem_one;

   assign in_ready  = ((state_q == IDLE) || (state_q == ABSORB_WAIT)) && !abort;
   assign accept    = in_valid && in_ready;
   assign absorb_en = accept;
   assign state_clr = accept && (state_q == IDLE);
   assign round_en  = (state_q == PERMUTE) && !abort;
   assign rem_one   = (remaining_q == OUT_CNT_W'(1));
   assign out_valid = (state_q == OUTPUT);
   assign out_last  = out_valid && rem_one;
   assign out_hs    = out_valid && out_ready;
   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;

   round_counter #(
      .NUM_ROUNDS (NUM_ROUNDS),
      .ROUND_W    (ROUND_W)
   ) u_round_counter (
      .clk  (clk),
      .rst  (rst),
      .en   (round_en),
      .clr  (abort),
      .idx  (round_idx),
      .last (rc_last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (accept) state_d = PERMUTE;
         PERMUTE:     if (rc_last) state_d = (squeeze_q || last_q) ? OUTPUT : ABSORB_WAIT;
         ABSORB_WAIT: if (accept) state_d = PERMUTE;
         OUTPUT:      if (out_ready) state_d = rem_one ? IDLE : PERMUTE;
         default:     state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         mode_q      <= 1'b0;
         last_q      <= 1'b0;
         squeeze_q   <= 1'b0;
      end else if (abort) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         last_q      <= 1'b0;
         squeeze_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_clr) begin
            // A zero request still yields one block so the hash always produces output.
            remaining_q <= (in_out_blocks == '0) ? OUT_CNT_W'(1) : in_out_blocks;
            mode_q      <= in_mode;
            last_q      <= in_last;
            squeeze_q   <= 1'b0;
         end else if (accept) begin
            last_q <= in_last;
         end
         if (out_hs) begin
            if (rem_one) begin
               remaining_q <= '0;
            end else begin
               remaining_q <= remaining_q - OUT_CNT_W'(1);
               squeeze_q   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sponge_ctrl.sv
// Directed bench for sponge_ctrl: table of whole-hash vectors plus abort and reset corner sequences.
module tb_sponge_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        abort;
   logic        in_valid;
   logic        in_last;
   logic        in_mode;
   logic [15:0] in_out_blocks;
   logic        out_ready;

   logic        in_ready, absorb_en, state_clr, round_en, mode_q, out_valid, out_last, busy;
   logic [4:0]  round_idx;
   logic [1:0]  state_dbg;

   logic        b_in_ready, b_absorb_en, b_state_clr, b_round_en, b_mode_q, b_out_valid, b_out_last, b_busy;
   logic [3:0]  b_round_idx;
   logic [1:0]  b_state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sponge_ctrl dut (
      .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_last(in_last),
      .in_mode(in_mode), .in_out_blocks(in_out_blocks), .out_ready(out_ready),
      .in_ready(in_ready), .absorb_en(absorb_en), .state_clr(state_clr), .round_en(round_en),
      .round_idx(round_idx), .mode_q(mode_q), .out_valid(out_valid), .out_last(out_last),
      .busy(busy), .state_dbg(state_dbg)
   );

   sponge_ctrl #(.NUM_ROUNDS(12)) dut12 (
      .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_last(in_last),
      .in_mode(in_mode), .in_out_blocks(in_out_blocks), .out_ready(out_ready),
      .in_ready(b_in_ready), .absorb_en(b_absorb_en), .state_clr(b_state_clr), .round_en(b_round_en),
      .round_idx(b_round_idx), .mode_q(b_mode_q), .out_valid(b_out_valid), .out_last(b_out_last),
      .busy(b_busy), .state_dbg(b_state_dbg)
   );

   typedef struct {
      logic        mode;
      logic [15:0] ob;
      int          nblk;
      int          stall_blk;
      int          stall_cyc;
      int          exp_outs;
      int          exp_re;
      int          exp_busy;
      int          exp_first;
      int          exp_gap;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      int cyc = 0, acc0 = -1, last_acc = -1, last_gap = 0, gap_bad = 0;
      int n_acc = 0, clr_cnt = 0, absorb_bad = 0, re_cnt = 0, busy_cnt = 0;
      int outs = 0, lasts = 0, bad_last = 0, first_out = -1;
      int mode_bad = 0, stab_bad = 0, stall_left, stall_seen = 0, rdy_bad = 0;
      bit done = 0, stalling = 0, held_last = 0;
      logic [4:0] held_idx = '0;
      logic [1:0] held_st = '0;
      stall_left = v.stall_cyc;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         in_valid      = (n_acc < v.nblk);
         in_last       = (n_acc == v.nblk - 1);
         in_mode       = v.mode;
         in_out_blocks = v.ob;
         out_ready     = !(out_valid && (outs + 1 == v.stall_blk) && (stall_left > 0));
         #1;
         if (busy) busy_cnt++;
         if (round_en) re_cnt++;
         if (busy && mode_q !== v.mode) mode_bad++;
         if (in_ready && out_valid) rdy_bad++;
         if (in_valid && in_ready) begin
            if (state_clr) clr_cnt++;
            if (!absorb_en) absorb_bad++;
            if (acc0 < 0) acc0 = cyc;
            else begin
               last_gap = cyc - last_acc;
               if (last_gap != 25) gap_bad++;
            end
            last_acc = cyc;
            n_acc++;
         end else if (absorb_en || state_clr) absorb_bad++;
         if (out_valid && first_out < 0 && acc0 >= 0) first_out = cyc - acc0;
         if (!out_ready) begin
            if (stalling) begin
               if (out_last !== held_last || out_valid !== 1'b1 || round_idx !== held_idx || state_dbg !== held_st)
                  stab_bad++;
            end else begin
               held_last = out_last; held_idx = round_idx; held_st = state_dbg; stalling = 1;
            end
            stall_left--;
            stall_seen++;
         end else if (stalling) begin
            if (out_valid !== 1'b1 || out_last !== held_last) stab_bad++;
            stalling = 0;
         end
         if (out_valid && out_ready) begin
            outs++;
            if (out_last) lasts++;
            if (out_last !== (outs == v.exp_outs)) bad_last++;
         end
         if (acc0 >= 0 && outs > 0 && !busy) done = 1;
         cyc++;
      end
      chk($sformatf("v%0d_timeout", vi), done, 1);
      chk($sformatf("v%0d_accepts", vi), n_acc, v.nblk);
      chk($sformatf("v%0d_state_clr", vi), clr_cnt, 1);
      chk($sformatf("v%0d_absorb_en", vi), absorb_bad, 0);
      chk($sformatf("v%0d_accept_gap", vi), last_gap, v.exp_gap);
      chk($sformatf("v%0d_gap_bad", vi), gap_bad, 0);
      chk($sformatf("v%0d_round_en_cnt", vi), re_cnt, v.exp_re);
      chk($sformatf("v%0d_busy_cnt", vi), busy_cnt, v.exp_busy);
      chk($sformatf("v%0d_first_out", vi), first_out, v.exp_first);
      chk($sformatf("v%0d_out_blocks", vi), outs, v.exp_outs);
      chk($sformatf("v%0d_out_last_cnt", vi), lasts, 1);
      chk($sformatf("v%0d_out_last_pos", vi), bad_last, 0);
      chk($sformatf("v%0d_mode_q", vi), mode_bad, 0);
      chk($sformatf("v%0d_stall_seen", vi), stall_seen, v.stall_cyc);
      chk($sformatf("v%0d_stall_stable", vi), stab_bad, 0);
      chk($sformatf("v%0d_in_ready_in_output", vi), rdy_bad, 0);
      chk($sformatf("v%0d_idx_end", vi), round_idx, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_absorb_en"}, absorb_en, 0);
      chk({tag, "_state_clr"}, state_clr, 0);
      chk({tag, "_round_en"}, round_en, 0);
      chk({tag, "_round_idx"}, round_idx, 0);
      chk({tag, "_mode_q"}, mode_q, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, cnt, ov_cnt, k;
      bit seen;
      //           mode  ob     nblk stb stc outs re  busy first gap
      vecs[0] = '{1'b0, 16'd1, 1,   0,  0,  1,   24, 25,  25,   0};
      vecs[1] = '{1'b1, 16'd1, 3,   0,  0,  1,   72, 75,  75,   25};
      vecs[2] = '{1'b0, 16'd3, 1,   2,  5,  3,   72, 80,  25,   0};
      vecs[3] = '{1'b1, 16'd0, 1,   0,  0,  1,   24, 25,  25,   0};
      vecs[4] = '{1'b1, 16'd2, 2,   1,  3,  2,   72, 78,  50,   25};

      rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0;
      in_out_blocks = 16'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_during");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_after");

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // Abort at round 10 of the second absorbed block.
      acc = 0; seen = 0; k = 0;
      while (!seen && k < 200) begin
         @(negedge clk);
         in_valid = (acc < 2); in_last = 1'b0; in_mode = 1'b0; in_out_blocks = 16'd1; out_ready = 1'b1;
         #1;
         if (in_valid && in_ready) acc++;
         else if (acc == 2 && round_en && round_idx == 5'd10) begin
            abort = 1'b1;
            #1;
            chk("abort_absorb_en", absorb_en, 0);
            chk("abort_round_en", round_en, 0);
            seen = 1;
         end
         k++;
      end
      chk("abort_reached", seen, 1);
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      #1;
      chk("abort_state_idle", state_dbg, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_round_idx", round_idx, 0);
      chk("abort_busy", busy, 0);
      ov_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (out_valid || busy) ov_cnt++;
      end
      chk("abort_no_out_valid", ov_cnt, 0);

      // Reset mid-OUTPUT on the 12-round instance, then a fresh hash.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; in_last = 1'b1; in_mode = 1'b1; in_out_blocks = 16'd2; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!b_out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("r12_first_out_valid", b_out_valid, 1);
      chk("r12_mode_before_rst", b_mode_q, 1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("r12_rst_state", b_state_dbg, 0);
      chk("r12_rst_out_valid", b_out_valid, 0);
      chk("r12_rst_in_ready", b_in_ready, 1);
      chk("r12_rst_round_idx", b_round_idx, 0);
      chk("r12_rst_mode_q", b_mode_q, 0);
      chk("r12_rst_busy", b_busy, 0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; in_last = 1'b1; in_mode = 1'b1; in_out_blocks = 16'd1; out_ready = 1'b0;
      #1;
      chk("r12_new_state_clr", b_state_clr, 1);
      @(negedge clk);
      in_valid = 1'b0;
      cnt = 0; k = 0;
      #1;
      while (!b_out_valid && k < 100) begin
         if (b_round_en) cnt++;
         @(negedge clk);
         #1;
         k++;
      end
      chk("r12_round_cnt", cnt, 12);
      chk("r12_new_mode_q", b_mode_q, 1);
      chk("r12_out_last", b_out_last, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("r12_busy_after", b_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sponge_ctrl.md
SPONGE_CTRL -- requirements
Module: sponge_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 24, permutation rounds per block; legal range 2..64.
REQ-002 Parameter OUT_CNT_W, default 16, width of the squeeze block count.
REQ-003 Parameter ROUND_W, default $clog2(NUM_ROUNDS), width of round_idx.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 abort  in  1  synchronous abandon of the current hash.
REQ-007 in_valid  in  1  padded rate block present at input.
REQ-008 in_last  in  1  qualifies in_valid; final block of message.
REQ-009 in_mode  in  1  0 = SHAKE128 (rate 168 B), 1 = SHAKE256 (rate 136 B); sampled on first block.
REQ-010 in_out_blocks  in  OUT_CNT_W  requested squeeze blocks; sampled on first block.
REQ-011 out_ready  in  1  downstream accepts the current output block.
REQ-012 in_ready  out  1  block accepted when in_valid && in_ready.
REQ-013 absorb_en  out  1  datapath XORs input block into state this cycle.
REQ-014 state_clr  out  1  with absorb_en: datapath loads block into zeroed state.
REQ-015 round_en  out  1  datapath applies round round_idx this cycle.
REQ-016 round_idx  out  ROUND_W  current round number (iota constant select).
REQ-017 mode_q  out  1  captured mode, held for whole hash.
REQ-018 out_valid  out  1  state holds a valid squeeze block.
REQ-019 out_last  out  1  qualifies out_valid; final requested block.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 States: IDLE, PERMUTE, ABSORB_WAIT, OUTPUT; all outputs are decoded combinationally from state and registers.
REQ-022 IDLE: in_ready=1; on accept, absorb_en=1, state_clr=1, capture in_mode, in_out_blocks (0 treated as 1), in_last into last_q; clear squeeze flag; go PERMUTE with round_idx=0.
REQ-023 PERMUTE: round_en=1, in_ready=0; round_idx increments each cycle from 0 to NUM_ROUNDS-1, then wraps to 0 on exit.
REQ-024 PERMUTE exit at round_idx==NUM_ROUNDS-1: to OUTPUT if squeeze flag or last_q set, else to ABSORB_WAIT.
REQ-025 ABSORB_WAIT: in_ready=1; on accept, absorb_en=1 (state_clr=0), update last_q, go PERMUTE; otherwise hold.
REQ-026 Absorb throughput: exactly 1 + NUM_ROUNDS cycles per block when in_valid is held high.
REQ-027 OUTPUT: out_valid=1, out_last=(remaining==1); on out_ready: if remaining==1 go IDLE, else decrement remaining, set squeeze flag, go PERMUTE.
REQ-028 out_valid, out_last and the presented block remain stable until out_ready; no state change while stalled.
REQ-029 in_valid outside IDLE/ABSORB_WAIT is ignored and nothing is consumed.
REQ-030 abort has priority over every transition: next state IDLE, round_idx=0, remaining=0, flags cleared; absorb_en and round_en forced 0 in that cycle.
REQ-031 The new hash's first block is accepted no earlier than the cycle after the final out_ready handshake.
REQ-032 remaining never underflows; it is loaded only from IDLE.

Reset
REQ-033 rst asserted: state=IDLE, round_idx=0, remaining=0, mode_q=0, last_q=0, squeeze flag=0 immediately, independent of clk.
REQ-034 During and after reset: in_ready=1, all other outputs 0; a reset mid-permutation or mid-output discards the hash.

Structure
REQ-035 Package sponge_pkg holds the state enum, mode enum, RATE_128=168 and RATE_256=136 byte constants, and the NUM_ROUNDS default.
REQ-036 Sub-module round_counter (parameter NUM_ROUNDS; inputs en, clr; outputs idx, last) provides round_idx and the terminal-round flag.

Verification
REQ-037 Single block, in_last=1, in_out_blocks=1, out_ready=1 -> 24 round_en cycles, out_valid with out_last in cycle 25 after accept, busy falls next cycle.
REQ-038 Three blocks back-to-back with in_valid held -> accepts 25 cycles apart; state_clr asserted only on the first.
REQ-039 in_out_blocks=3, out_ready low for 5 cycles on block 2 -> 3 out_valid pulses, 24-cycle permute between them, out_last only on the third, outputs stable while stalled.
REQ-040 in_out_blocks=0 -> exactly one output block, with out_last=1.
REQ-041 abort at round 10 of the second block -> next cycle IDLE, in_ready=1, round_idx=0, no out_valid.
REQ-042 rst pulse mid-OUTPUT with NUM_ROUNDS=12 -> immediate IDLE; a following hash permutes for 12 rounds with mode_q set by the new in_mode.
